// File: rtl/ysyx_2022040010_mem.sv
// ysyx_2022040010_mem: MEM stage, load request/response and WB/bypass buses.
// Define YSYX_2022040010_DMEM_TIMEOUT_EN to bound the wait on dmem_rvalid.
module ysyx_2022040010_mem #(
  parameter int STALL_W   = 6,
  parameter int STALL_IDX = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [63:0]        ex_pc,
  input  logic [63:0]        ex_npc,
  input  logic [31:0]        ex_inst,
  input  logic [2:0]         ex_sp,
  input  logic               ex_rf_we,
  input  logic [4:0]         ex_rf_waddr,
  input  logic [63:0]        ex_result,
  input  logic               ex_load,
  input  logic [2:0]         ex_funct3,
  output logic               dmem_req,
  output logic [63:0]        dmem_addr,
  input  logic               dmem_rvalid,
  input  logic [63:0]        dmem_rdata,
  output logic               stallreq_mem,
  output logic [232:0]       mem_to_wb_bus,
  output logic [69:0]        mem_to_rf_bus,
  output logic               dmem_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic        valid_r;
  logic [63:0] pc_r;
  logic [63:0] npc_r;
  logic [31:0] inst_r;
  logic [2:0]  sp_r;
  logic        we_r;
  logic [4:0]  waddr_r;
  logic [63:0] res_r;
  logic        is_load_r;
  logic [2:0]  f3_r;
  logic [63:0] load_r, load_n;
  logic        capture;
  logic        tmo;
  logic        waiting;
  logic        bubble;
  logic [63:0] raw;
  logic [63:0] shifted;
  logic [63:0] ext;
  logic [63:0] wdata;
  logic        stall_unused;

  assign stall_unused = ^stall;
  assign capture = ~stall[STALL_IDX];

`ifdef YSYX_2022040010_DMEM_TIMEOUT_EN
  logic [7:0] cnt, cnt_n;

  assign tmo = (state == WAIT) & ~dmem_rvalid
             & (cnt == 8'(TIMEOUT));

  always_comb begin
    cnt_n = cnt;
    if (state == WAIT) cnt_n = cnt + 8'd1;
    if (capture) cnt_n = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= 8'd0;
    else     cnt <= cnt_n;
  end
`else
  assign tmo = 1'b0;
`endif

  assign dmem_err = tmo;

  // A fresh capture always wins; WAIT only resolves while the input holds.
  always_comb begin
    state_n = state;
    load_n  = load_r;
    unique case (state)
      WAIT: begin
        if (dmem_rvalid) begin
          state_n = DONE;
          load_n  = dmem_rdata;
        end else if (tmo) begin
          state_n = DONE;
          load_n  = '0;
        end
      end
      default: ;
    endcase
    if (capture)
      state_n = (ex_valid & ex_load) ? WAIT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_r    <= '0;
      valid_r   <= 1'b0;
      pc_r      <= '0;
      npc_r     <= '0;
      inst_r    <= '0;
      sp_r      <= '0;
      we_r      <= 1'b0;
      waddr_r   <= '0;
      res_r     <= '0;
      is_load_r <= 1'b0;
      f3_r      <= '0;
    end else begin
      state  <= state_n;
      load_r <= load_n;
      if (capture) begin
        valid_r   <= ex_valid;
        pc_r      <= ex_pc;
        npc_r     <= ex_npc;
        inst_r    <= ex_inst;
        sp_r      <= ex_sp;
        we_r      <= ex_rf_we;
        waddr_r   <= ex_rf_waddr;
        res_r     <= ex_result;
        is_load_r <= ex_load;
        f3_r      <= ex_funct3;
      end
    end
  end

  assign waiting      = (state == WAIT) & ~dmem_rvalid & ~tmo;
  assign stallreq_mem = waiting;
  assign dmem_req     = (state == WAIT);
  assign dmem_addr    = {res_r[63:3], 3'b000};

  always_comb begin
    raw = load_r;
    if (state == WAIT) begin
      if (dmem_rvalid) raw = dmem_rdata;
      else if (tmo)    raw = '0;
    end
  end

  assign shifted = raw >> {res_r[2:0], 3'b000};

  always_comb begin
    ext = shifted;
    unique case (f3_r)
      3'd0:    ext = {{56{shifted[7]}}, shifted[7:0]};
      3'd1:    ext = {{48{shifted[15]}}, shifted[15:0]};
      3'd2:    ext = {{32{shifted[31]}}, shifted[31:0]};
      3'd4:    ext = {56'd0, shifted[7:0]};
      3'd5:    ext = {48'd0, shifted[15:0]};
      3'd6:    ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  assign wdata  = is_load_r ? ext : res_r;
  assign bubble = ~valid_r | waiting;

  assign mem_to_wb_bus = bubble ? '0 :
    {sp_r, npc_r, pc_r, we_r, waddr_r, wdata, inst_r};

  assign mem_to_rf_bus = bubble ? '0 :
    {we_r & (waddr_r != 5'd0), waddr_r, wdata};

endmodule

// File: tb/tb_ysyx_2022040010_mem.sv
// tb_ysyx_2022040010_mem: scoreboard bench for the MEM stage.
// The bench also plays the stall controller, feeding stallreq_mem back.
module tb_ysyx_2022040010_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [5:0]   stall_ext;
  logic [5:0]   stall;
  logic         ex_valid;
  logic [63:0]  ex_pc;
  logic [63:0]  ex_npc;
  logic [31:0]  ex_inst;
  logic [2:0]   ex_sp;
  logic         ex_rf_we;
  logic [4:0]   ex_rf_waddr;
  logic [63:0]  ex_result;
  logic         ex_load;
  logic [2:0]   ex_funct3;
  logic         dmem_req;
  logic [63:0]  dmem_addr;
  logic         dmem_rvalid;
  logic [63:0]  dmem_rdata;
  logic         stallreq_mem;
  logic [232:0] mem_to_wb_bus;
  logic [69:0]  mem_to_rf_bus;
  logic         dmem_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [232:0] wb;
    logic [69:0]  rf;
  } exp_t;

  exp_t sb[$];

  assign stall = stall_ext | (stallreq_mem ? 6'b000111 : 6'b000000);

  ysyx_2022040010_mem dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_npc       (ex_npc),
    .ex_inst      (ex_inst),
    .ex_sp        (ex_sp),
    .ex_rf_we     (ex_rf_we),
    .ex_rf_waddr  (ex_rf_waddr),
    .ex_result    (ex_result),
    .ex_load      (ex_load),
    .ex_funct3    (ex_funct3),
    .dmem_req     (dmem_req),
    .dmem_addr    (dmem_addr),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .stallreq_mem (stallreq_mem),
    .mem_to_wb_bus(mem_to_wb_bus),
    .mem_to_rf_bus(mem_to_rf_bus),
    .dmem_err     (dmem_err)
  );

  function automatic exp_t mk(input logic [63:0] pc,
                              input logic [31:0] inst,
                              input logic [2:0]  sp,
                              input logic        we,
                              input logic [4:0]  wa,
                              input logic [63:0] wd);
    exp_t e;
    e.wb = {sp, pc + 64'd4, pc, we, wa, wd, inst};
    e.rf = {we & (wa != 5'd0), wa, wd};
    return e;
  endfunction

  task automatic drive(input logic [63:0] pc,
                       input logic [31:0] inst,
                       input logic [2:0]  sp,
                       input logic        we,
                       input logic [4:0]  wa,
                       input logic [63:0] res,
                       input logic        ld,
                       input logic [2:0]  f3);
    ex_valid    = 1'b1;
    ex_pc       = pc;
    ex_npc      = pc + 64'd4;
    ex_inst     = inst;
    ex_sp       = sp;
    ex_rf_we    = we;
    ex_rf_waddr = wa;
    ex_result   = res;
    ex_load     = ld;
    ex_funct3   = f3;
  endtask

  task automatic idle_in();
    ex_valid    = 1'b0;
    ex_pc       = '0;
    ex_npc      = '0;
    ex_inst     = '0;
    ex_sp       = '0;
    ex_rf_we    = 1'b0;
    ex_rf_waddr = '0;
    ex_result   = '0;
    ex_load     = 1'b0;
    ex_funct3   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_ext = '0;
    dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dmem_req, stallreq_mem, dmem_err} !== 3'b000 ||
        mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0 ||
        dmem_addr !== '0) begin
      errors++;
      $display("FAIL reset_during: req=%b stall=%b err=%b wb=%h rf=%h, required all 0",
               dmem_req, stallreq_mem, dmem_err, mem_to_wb_bus, mem_to_rf_bus);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({dmem_req, stallreq_mem, dmem_err} !== 3'b000 ||
        mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0) begin
      errors++;
      $display("FAIL reset_after: req=%b stall=%b wb=%h rf=%h, required all 0",
               dmem_req, stallreq_mem, mem_to_wb_bus, mem_to_rf_bus);
    end
  endtask

  task automatic test_alu();
    exp_t e;
    @(posedge clk); #1;
    drive(64'h8000_0000, 32'h0062_8293, 3'b101, 1'b1, 5'd5,
          64'h1234, 1'b0, 3'd0);
    sb.push_back(mk(64'h8000_0000, 32'h0062_8293, 3'b101,
                    1'b1, 5'd5, 64'h1234));
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || stallreq_mem !== 1'b0) begin
      errors++;
      $display("FAIL alu_ctrl: req=%b stall=%b, required 0 0",
               dmem_req, stallreq_mem);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL alu_bus: queue empty, required one entry");
    end else begin
      e = sb.pop_front();
      if (mem_to_wb_bus !== e.wb || mem_to_rf_bus !== e.rf) begin
        errors++;
        $display("FAIL alu_bus: wb=%h rf=%h, required wb=%h rf=%h",
                 mem_to_wb_bus, mem_to_rf_bus, e.wb, e.rf);
      end
    end
  endtask

  task automatic test_load(input string nm,
                           input logic [2:0]  f3,
                           input logic [63:0] addr,
                           input int          lat,
                           input logic [63:0] rd,
                           input logic [63:0] expw);
    exp_t e;
    @(posedge clk); #1;
    drive(64'h8000_1000, 32'h0000_0003, 3'b010, 1'b1, 5'd10,
          addr, 1'b1, f3);
    sb.push_back(mk(64'h8000_1000, 32'h0000_0003, 3'b010,
                    1'b1, 5'd10, expw));
    @(posedge clk); #1;
    idle_in();
    dmem_rdata = rd;
    dmem_rvalid = (lat == 0);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (stallreq_mem !== 1'b1 || dmem_req !== 1'b1 ||
          mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0) begin
        errors++;
        $display("FAIL %s_wait%0d: stall=%b req=%b wb=%h, required 1 1 0",
                 nm, i, stallreq_mem, dmem_req, mem_to_wb_bus);
      end
      @(posedge clk); #1;
      dmem_rvalid = (i == lat - 1);
    end
    @(negedge clk);
    checks++;
    if (stallreq_mem !== 1'b0 || dmem_req !== 1'b1 ||
        dmem_addr !== {addr[63:3], 3'b000}) begin
      errors++;
      $display("FAIL %s_req: stall=%b req=%b addr=%h, required 0 1 %h",
               nm, stallreq_mem, dmem_req, dmem_addr,
               {addr[63:3], 3'b000});
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_bus: queue empty, required one entry", nm);
    end else begin
      e = sb.pop_front();
      if (mem_to_wb_bus !== e.wb || mem_to_rf_bus !== e.rf) begin
        errors++;
        $display("FAIL %s_bus: wb=%h rf=%h, required wb=%h rf=%h",
                 nm, mem_to_wb_bus, mem_to_rf_bus, e.wb, e.rf);
      end
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || mem_to_wb_bus !== '0) begin
      errors++;
      $display("FAIL %s_after: req=%b wb=%h, required 0 0",
               nm, dmem_req, mem_to_wb_bus);
    end
  endtask

  task automatic test_lwu_stall();
    exp_t e;
    exp_t e2;
    @(posedge clk); #1;
    drive(64'h8000_2000, 32'h0000_6003, 3'b001, 1'b1, 5'd12,
          64'h8000_0004, 1'b1, 3'd6);
    sb.push_back(mk(64'h8000_2000, 32'h0000_6003, 3'b001,
                    1'b1, 5'd12, 64'h0000_0000_FEDC_BA98));
    @(posedge clk); #1;
    drive(64'h8000_2004, 32'h0000_0013, 3'b000, 1'b1, 5'd13,
          64'h55, 1'b0, 3'd0);
    stall_ext = 6'b000111;
    dmem_rvalid = 1'b1;
    dmem_rdata = 64'hFEDC_BA98_7654_3210;
    @(negedge clk);
    checks++;
    e = '0;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL lwu_bus: queue empty, required one entry");
    end else begin
      e = sb.pop_front();
      if (mem_to_wb_bus !== e.wb || mem_to_rf_bus !== e.rf) begin
        errors++;
        $display("FAIL lwu_bus: wb=%h rf=%h, required wb=%h rf=%h",
                 mem_to_wb_bus, mem_to_rf_bus, e.wb, e.rf);
      end
    end
    sb.push_back(mk(64'h8000_2004, 32'h0000_0013, 3'b000,
                    1'b1, 5'd13, 64'h55));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      dmem_rdata = '1;
      if (i == 3) stall_ext = '0;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== e.wb || mem_to_rf_bus !== e.rf ||
          stallreq_mem !== 1'b0 || dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL lwu_hold%0d: wb=%h stall=%b req=%b, required wb=%h 0 0",
                 i, mem_to_wb_bus, stallreq_mem, dmem_req, e.wb);
      end
    end
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL lwu_next: queue empty, required one entry");
    end else begin
      e2 = sb.pop_front();
      if (mem_to_wb_bus !== e2.wb || mem_to_rf_bus !== e2.rf) begin
        errors++;
        $display("FAIL lwu_next: wb=%h rf=%h, required wb=%h rf=%h",
                 mem_to_wb_bus, mem_to_rf_bus, e2.wb, e2.rf);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    drive(64'h8000_3000, 32'h0000_0003, 3'b000, 1'b1, 5'd9,
          64'h8000_0003, 1'b1, 3'd0);
    @(posedge clk); #1;
    idle_in();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (stallreq_mem !== 1'b1 || dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstw_pre: stall=%b req=%b, required 1 1",
               stallreq_mem, dmem_req);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({dmem_req, stallreq_mem, dmem_err} !== 3'b000 ||
        mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0) begin
      errors++;
      $display("FAIL rstw_drop: req=%b stall=%b wb=%h rf=%h, required all 0",
               dmem_req, stallreq_mem, mem_to_wb_bus, mem_to_rf_bus);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || mem_to_wb_bus !== '0) begin
      errors++;
      $display("FAIL rstw_after: req=%b wb=%h, required 0 0",
               dmem_req, mem_to_wb_bus);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata = 64'h0000_0000_8000_0000;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || stallreq_mem !== 1'b0 ||
        mem_to_wb_bus !== '0 || mem_to_rf_bus !== '0) begin
      errors++;
      $display("FAIL rstw_late: req=%b stall=%b wb=%h rf=%h, required all 0",
               dmem_req, stallreq_mem, mem_to_wb_bus, mem_to_rf_bus);
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_to_rf_bus !== '0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rstw_idle: rf=%h req=%b, required 0 0",
               mem_to_rf_bus, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [63:0] pcs [3];
    pcs[0] = 64'h8000_4000;
    pcs[1] = 64'h8000_4004;
    pcs[2] = 64'h8000_4008;
    @(posedge clk); #1;
    drive(pcs[0], 32'h0010_0093, 3'b100, 1'b1, 5'd1,
          64'hAAAA, 1'b0, 3'd0);
    sb.push_back(mk(pcs[0], 32'h0010_0093, 3'b100, 1'b1, 5'd1, 64'hAAAA));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      if (i == 0) begin
        drive(pcs[1], 32'h0000_3003, 3'b011, 1'b1, 5'd2,
              64'h8000_0010, 1'b1, 3'd3);
        sb.push_back(mk(pcs[1], 32'h0000_3003, 3'b011, 1'b1, 5'd2,
                        64'h0123_4567_89AB_CDEF));
      end else if (i == 1) begin
        drive(pcs[2], 32'h0050_0013, 3'b000, 1'b1, 5'd0,
              64'h77, 1'b0, 3'd0);
        sb.push_back(mk(pcs[2], 32'h0050_0013, 3'b000, 1'b1, 5'd0, 64'h77));
        dmem_rvalid = 1'b1;
        dmem_rdata = 64'h0123_4567_89AB_CDEF;
      end else begin
        idle_in();
      end
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_%0d: queue empty, required one entry", i);
      end else begin
        e = sb.pop_front();
        if (mem_to_wb_bus !== e.wb || mem_to_rf_bus !== e.rf ||
            stallreq_mem !== 1'b0) begin
          errors++;
          $display("FAIL b2b_%0d: wb=%h rf=%h stall=%b, required wb=%h rf=%h 0",
                   i, mem_to_wb_bus, mem_to_rf_bus, stallreq_mem, e.wb, e.rf);
        end
      end
    end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load("ld", 3'd3, 64'h8000_0008, 0,
              64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D);
    test_load("lb", 3'd0, 64'h8000_0003, 3,
              64'h1122_3344_80AA_BBCC, 64'hFFFF_FFFF_FFFF_FF80);
    test_load("lbu", 3'd4, 64'h8000_0003, 3,
              64'h1122_3344_80AA_BBCC, 64'h0000_0000_0000_0080);
    test_load("lh", 3'd1, 64'h8000_0006, 1,
              64'h8001_2222_3333_4444, 64'hFFFF_FFFF_FFFF_8001);
    test_load("lhu", 3'd5, 64'h8000_0002, 2,
              64'h0000_0000_BEEF_0000, 64'h0000_0000_0000_BEEF);
    test_load("lw", 3'd2, 64'h8000_0000, 1,
              64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_9ABC_DEF0);
    test_load("f3_7", 3'd7, 64'h8000_0010, 0,
              64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    test_lwu_stall();
    test_reset_in_wait();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_mem.md
Name: ysyx_2022040010_mem

Overview:
- Memory-access pipeline stage directly upstream of the write-back stage.
- Registers the EX-stage result and issues the data-memory read for load instructions over a request/response handshake.
- Aligns and sign/zero-extends load data and produces `mem_to_wb_bus` in exactly the field order write-back unpacks.
- Asserts a stall request while a load is outstanding, and drives a bypass bus toward decode.

Parameters:
- STALL_W, 6, width of the stall bus.
- STALL_IDX, 2, stall bit that freezes this stage's input register.
- TIMEOUT, 255, maximum wait cycles for dmem_rvalid (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  STALL_W  stall vector from the stall controller.
- ex_valid  in  1  EX entry valid.
- ex_pc  in  64  instruction PC.
- ex_npc  in  64  next PC.
- ex_inst  in  32  instruction word.
- ex_sp  in  3  {sp_bus[1:0], op_sp}.
- ex_rf_we  in  1  register write enable.
- ex_rf_waddr  in  5  destination register.
- ex_result  in  64  ALU result; this is the load address for loads.
- ex_load  in  1  entry is a load.
- ex_funct3  in  3  load size/sign.
- dmem_req  out  1  read request.
- dmem_addr  out  64  {ex_result_r[63:3],3'b0}.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  64  read doubleword.
- stallreq_mem  out  1  request to stall stages 0..STALL_IDX.
- mem_to_wb_bus  out  233  {sp_bus[1:0], op_sp, npc, pc, rf_we, rf_waddr, rf_wdata, inst}.
- mem_to_rf_bus  out  70  {rf_we, rf_waddr, rf_wdata} bypass.
- dmem_err  out  1  timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Input register: on a rising edge with rst=1, all fields are cleared and the FSM goes to IDLE. Otherwise, if stall[STALL_IDX]=1, the register holds. Otherwise all ex_* fields are captured.
- FSM state IDLE: no request is outstanding.
- FSM state WAIT: dmem_req=1.
- FSM state DONE: the load has completed and its data is held.
- Transition on capture: next state is WAIT if ex_valid&ex_load, else IDLE.
- Transition in WAIT: when dmem_rvalid=1, latch dmem_rdata into load_r and go to DONE in the next cycle. dmem_rvalid is legal in the same cycle dmem_req first rises (zero-wait).
- DONE holds until the next capture.
- IDLE ignores dmem_rvalid.
- stallreq_mem = (state==WAIT) & ~dmem_rvalid.
- Load data source: raw = dmem_rvalid ? dmem_rdata : load_r while in WAIT; raw = load_r in DONE.
- Load alignment: shifted = raw >> (addr[2:0]*8).
- Load extension by funct3:
  - 0: LB, sign-extend 8 bits.
  - 1: LH, sign-extend 16 bits.
  - 2: LW, sign-extend 32 bits.
  - 3: LD, full 64 bits.
  - 4: LBU, zero-extend 8 bits.
  - 5: LHU, zero-extend 16 bits.
  - 6: LWU, zero-extend 32 bits.
  - 7: treated as LD.
- Misaligned accesses crossing a doubleword are unsupported; only bytes within the doubleword are returned.
- rf_wdata = extended load data for loads, else ex_result_r.
- Bubble: mem_to_wb_bus and mem_to_rf_bus are all-zero when the entry is invalid or (state==WAIT & ~dmem_rvalid). Write-back treats pc==0 as a bubble.
- mem_to_rf_bus rf_we is forced 0 when rf_waddr==0.
- All outputs are 0 during and immediately after reset.
- Simultaneous dmem_rvalid and stall[STALL_IDX]=1: data is latched into load_r and the FSM moves to DONE; the input register holds.
- Reset during WAIT: dmem_req drops in the next cycle; a late rvalid is ignored.

Optional Feature:
- Macro: YSYX_2022040010_DMEM_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT without rvalid, the FSM goes to DONE with load_r=0, dmem_err=1 for one cycle, and stallreq_mem drops.
- Disabled: no counter; WAIT is held indefinitely; dmem_err is constant 0.

Test Plan:
- Non-load: ADD result 0x1234, waddr 5, we=1 -> same cycle after capture, bus rf_wdata=0x1234 with pc/npc/inst passed through; dmem_req=0; stallreq_mem=0.
- LD at 0x80000008 with rvalid in the same cycle as req, rdata=0xDEADBEEF_CAFEF00D -> dmem_addr=0x80000008, no stall, rf_wdata=0xDEADBEEFCAFEF00D.
- LB at 0x80000003 with rvalid after 3 cycles, rdata byte3=0x80 -> stallreq_mem=1 for 3 cycles, WB bus zero during the wait, then rf_wdata=0xFFFFFFFFFFFFFF80. The same case with LBU gives 0x80.
- LWU at 0x...4 completes, then stall[2]=1 for 4 cycles -> DONE held, bus stable with upper word zero-extended; a new entry is captured when stall[2] returns to 0.
- rst asserted in WAIT -> next cycle dmem_req=0, all outputs 0; an rvalid pulse 2 cycles later produces no WB write.
- With the macro enabled, TIMEOUT=4 and no rvalid -> dmem_err pulses after 4 WAIT cycles, rf_wdata=0, stallreq_mem released.
